// File: rtl/neopixel_core.sv
// ==== neopixel_core: memory-mapped WS2812 pixel memory and one-wire serialiser ====
// Revision 1.0
`default_nettype none

module neopixel_core #(
  parameter int NUM_PIXELS = 64,
  parameter int T0H_CYC    = 50,
  parameter int T1H_CYC    = 100,
  parameter int TBIT_CYC   = 156,
  parameter int TRESET_CYC = 10000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        neopixel_drive,
  input  logic        clock_ctrl,
  input  logic        reset_ctrl,
  input  logic        write_readf,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int IW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CMAX = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [8:0] NPIX = 9'(NUM_PIXELS);

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, GAP} state_t;

  state_t        state;
  logic [23:0]   pixels [NUM_PIXELS];
  logic [23:0]   shift;
  logic [4:0]    bit_cnt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [8:0]    count_reg;
  logic [8:0]    frame_cnt;
  logic          auto_en;
  logic          strobe_prev;

  logic          commit, wr, rd, start, last_pixel;
  logic          sel_ctrl, sel_count, sel_pix;
  logic [29:0]   word, pix_off;
  logic [IW-1:0] pix_idx;
  logic [8:0]    count_wr;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
  endfunction

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? CW'(TBIT_CYC - T1H_CYC - 1) : CW'(TBIT_CYC - T0H_CYC - 1);
  endfunction

  assign word       = address[31:2];
  assign pix_off    = word - 30'h40;
  assign sel_ctrl   = (word == 30'h0);
  assign sel_count  = (word == 30'h1);
  assign sel_pix    = (word >= 30'h40) && (pix_off < 30'(NUM_PIXELS));
  assign pix_idx    = pix_off[IW-1:0];
  assign commit     = clock_ctrl & ~strobe_prev & ~reset_ctrl;
  assign wr         = commit & write_readf;
  assign rd         = commit & ~write_readf;
  assign start      = wr & sel_ctrl & write_data[0] & (state == IDLE);
  assign count_wr   = (write_data[8:0] == 9'd0 || write_data[8:0] > NPIX) ? NPIX : write_data[8:0];
  assign last_pixel = (9'(idx) + 9'd1) >= frame_cnt;
  assign unused_bits = ^{address[1:0], write_data[31:24]};

  always_comb begin
    rdata_next = '0;
    if (sel_ctrl)
      rdata_next = {30'd0, auto_en, state != IDLE};
    else if (sel_count)
      rdata_next = {23'd0, count_reg};
    else if (sel_pix)
      rdata_next = {8'h00, pixels[pix_idx]};
  end

  // Pixel memory deliberately has no reset; contents survive both resets.
  always_ff @(posedge clock) begin
    if (wr && sel_pix)
      pixels[pix_idx] <= write_data[23:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strobe_prev <= 1'b0;
      auto_en     <= 1'b0;
      count_reg   <= NPIX;
      read_data   <= '0;
    end else if (reset_ctrl) begin
      strobe_prev <= 1'b0;
      auto_en     <= 1'b0;
      count_reg   <= NPIX;
      read_data   <= '0;
    end else begin
      strobe_prev <= clock_ctrl;
      if (wr && sel_ctrl)  auto_en   <= write_data[1];
      if (wr && sel_count) count_reg <= count_wr;
      if (rd)              read_data <= rdata_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      neopixel_drive <= 1'b0;
      shift          <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      cnt            <= '0;
      frame_cnt      <= NPIX;
    end else if (reset_ctrl) begin
      state          <= IDLE;
      neopixel_drive <= 1'b0;
      shift          <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      cnt            <= '0;
      frame_cnt      <= NPIX;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx       <= '0;
          frame_cnt <= count_reg;
          state     <= LOAD;
        end
        LOAD: begin
          shift          <= pixels[idx];
          bit_cnt        <= 5'd23;
          cnt            <= high_len(pixels[idx][23]);
          neopixel_drive <= 1'b1;
          state          <= HIGH;
        end
        HIGH: if (cnt == '0) begin
          // The LOAD cycle of the next pixel is borrowed from this low period.
          neopixel_drive <= 1'b0;
          cnt   <= low_len(shift[23]) - ((bit_cnt == 5'd0 && !last_pixel) ? CW'(1) : CW'(0));
          state <= LOW;
        end else begin
          cnt <= cnt - CW'(1);
        end
        LOW: if (cnt == '0) begin
          if (bit_cnt != 5'd0) begin
            shift          <= {shift[22:0], 1'b0};
            bit_cnt        <= bit_cnt - 5'd1;
            cnt            <= high_len(shift[22]);
            neopixel_drive <= 1'b1;
            state          <= HIGH;
          end else if (!last_pixel) begin
            idx   <= idx + IW'(1);
            state <= LOAD;
          end else begin
            cnt   <= CW'(TRESET_CYC - 1);
            state <= GAP;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
        GAP: if (cnt == '0) begin
          if (auto_en) begin
            idx       <= '0;
            frame_cnt <= count_reg;
            state     <= LOAD;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neopixel_core.sv
// ==== tb_neopixel_core: waveform model plus directed register and frame checks ====
// Revision 1.0
`default_nettype none

module tb_neopixel_core;

  localparam int NP = 64, T0H = 50, T1H = 100, TBIT = 156, TRST = 10000;

  logic        clock = 1'b0, reset = 1'b0;
  logic        clock_ctrl = 1'b0, reset_ctrl = 1'b0, write_readf = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic        neopixel_drive;
  logic [31:0] read_data;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_commit = 0, start_c = 0, ok = 0;

  neopixel_core #(
    .NUM_PIXELS(NP), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRESET_CYC(TRST)
  ) dut (
    .clock(clock), .reset(reset), .neopixel_drive(neopixel_drive),
    .clock_ctrl(clock_ctrl), .reset_ctrl(reset_ctrl), .write_readf(write_readf),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #4 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one queue entry per future clock cycle holding the expected pin level and BUSY.
  typedef struct packed {logic drive; logic busy;} ent_t;
  ent_t        q[$];
  logic [23:0] m_pix [NP];
  logic        m_auto = 1'b0, m_prev = 1'b0, cur_busy = 1'b0;
  int          m_count = NP;
  logic [31:0] m_rdata = '0;

  task automatic push_frame();
    q.push_back('{drive: 1'b0, busy: 1'b1});
    for (int p = 0; p < m_count; p++)
      for (int b = 23; b >= 0; b--) begin
        int th;
        th = m_pix[p][b] ? T1H : T0H;
        for (int k = 0; k < TBIT; k++) q.push_back('{drive: (k < th), busy: 1'b1});
      end
    for (int k = 0; k < TRST; k++) q.push_back('{drive: 1'b0, busy: 1'b1});
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0) return {30'd0, m_auto, cur_busy};
    if (w == 32'h4) return 32'(m_count);
    if (w >= 32'h100 && w < 32'h100 + 4 * NP) return {8'h00, m_pix[int'((w - 32'h100) >> 2)]};
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    logic [31:0] w;
    if (!reset || reset_ctrl) begin
      q.delete();
      m_auto = 1'b0; m_prev = 1'b0; m_count = NP; m_rdata = '0;
    end else begin
      if (cur_busy && q.size() == 0 && m_auto) push_frame();
      if (clock_ctrl && !m_prev) begin
        w = address & 32'hFFFF_FFFC;
        if (!write_readf) begin
          m_rdata = m_read(address);
        end else if (w == 32'h0) begin
          m_auto = write_data[1];
          if (write_data[0] && !cur_busy) push_frame();
        end else if (w == 32'h4) begin
          m_count = (write_data[8:0] == 9'd0 || int'(write_data[8:0]) > NP) ? NP : int'(write_data[8:0]);
        end else if (w >= 32'h100 && w < 32'h100 + 4 * NP) begin
          m_pix[int'((w - 32'h100) >> 2)] = write_data[23:0];
        end
      end
      m_prev = clock_ctrl;
    end
  end

  always @(negedge clock) begin
    ent_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '0;
    cur_busy = e.busy;
    check("drive", {31'd0, neopixel_drive}, {31'd0, e.drive});
    check("read_data", read_data, m_rdata);
  end

  // Independent pulse recorder used for the literal waveform expectations.
  int   rises[$];
  int   widths[$];
  int   hw = 0;
  logic pd = 1'b0;
  always @(negedge clock) begin
    if (neopixel_drive && !pd) begin rises.push_back(cyc); hw = 0; end
    if (neopixel_drive) hw++;
    else if (pd) widths.push_back(hw);
    pd = neopixel_drive;
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    write_readf = w; address = a; write_data = d; clock_ctrl = 1'b1; last_commit = cyc;
    @(posedge clock); #1;
    clock_ctrl = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'h0);
    check(name, read_data, exp);
  endtask

  task automatic check_periods(input string name);
    ok = 1;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != TBIT) ok = 0;
    check(name, ok, 1);
  endtask

  initial begin
    logic [71:0] got;
    int n50;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_drive", {31'd0, neopixel_drive}, 32'h0);
    check("reset_rdata", read_data, 32'h0);
    reset = 1'b1;

    rd_check("ctrl_after_reset", 32'h0, 32'h0);
    rd_check("count_after_reset", 32'h4, 32'd64);
    bus(1'b1, 32'h114, 32'hFFA5_5A3C);
    rd_check("pixel5_readback", 32'h114, 32'h00A5_5A3C);
    bus(1'b1, 32'h4, 32'd0);
    rd_check("count_zero", 32'h4, 32'd64);
    bus(1'b1, 32'h4, 32'd3);
    rd_check("count_three", 32'h4, 32'd3);
    bus(1'b1, 32'h4, 32'd200);
    rd_check("count_over", 32'h4, 32'd64);
    bus(1'b1, 32'h1FC, 32'h0065_4321);
    rd_check("pixel63", 32'h1FC, 32'h0065_4321);
    bus(1'b1, 32'h200, 32'h0000_DEAD);
    rd_check("unmapped_read", 32'h200, 32'h0);

    @(posedge clock); #1;
    write_readf = 1'b1; address = 32'h11C; write_data = 32'h0011_1111; clock_ctrl = 1'b1;
    @(posedge clock); #1;
    write_data = 32'h0022_2222;
    repeat (3) @(posedge clock);
    #1 clock_ctrl = 1'b0;
    rd_check("held_strobe_once", 32'h11C, 32'h0011_1111);

    // Single pixel 0x800001: one long bit, 22 short bits, one long bit.
    bus(1'b1, 32'h4, 32'd1);
    bus(1'b1, 32'h100, 32'h0080_0001);
    rises.delete(); widths.delete();
    bus(1'b1, 32'h0, 32'h1);
    start_c = last_commit;
    rd_check("busy_during_frame", 32'h0, 32'h1);
    bus(1'b1, 32'h0, 32'h1);
    repeat (24 * TBIT + TRST + 20) @(posedge clock);
    #1;
    rd_check("idle_after_frame", 32'h0, 32'h0);
    check("pulses_single", rises.size(), 24);
    if (rises.size() == 24 && widths.size() == 24) begin
      check("start_latency", rises[0] - start_c, 2);
      check("width_first", widths[0], T1H);
      check("width_last", widths[23], T1H);
      n50 = 0;
      for (int i = 1; i < 23; i++) if (widths[i] == T0H) n50++;
      check("widths_middle", n50, 22);
    end
    check_periods("period_single");

    // Three pixels: continuous 72 bit periods, G7 of pixel 0 first.
    bus(1'b1, 32'h100, 32'h0012_3456);
    bus(1'b1, 32'h104, 32'h00AB_CDEF);
    bus(1'b1, 32'h108, 32'h000F_0F0F);
    bus(1'b1, 32'h4, 32'd3);
    rises.delete(); widths.delete();
    bus(1'b1, 32'h0, 32'h1);
    repeat (72 * TBIT + TRST + 20) @(posedge clock);
    #1;
    rd_check("idle_after_multi", 32'h0, 32'h0);
    check("pulses_multi", rises.size(), 72);
    check_periods("period_multi");
    got = '0;
    for (int i = 0; i < widths.size(); i++) got = {got[70:0], widths[i] == T1H};
    check("pixel0_bits", {8'h0, got[71:48]}, 32'h0012_3456);
    check("pixel1_bits", {8'h0, got[47:24]}, 32'h00AB_CDEF);
    check("pixel2_bits", {8'h0, got[23:0]}, 32'h000F_0F0F);

    // AUTO: second frame follows the gap plus one LOAD cycle; clearing AUTO stops after it.
    bus(1'b1, 32'h100, 32'h00F0_F0F0);
    bus(1'b1, 32'h4, 32'd1);
    rises.delete(); widths.delete();
    bus(1'b1, 32'h0, 32'h3);
    repeat (24 * TBIT + TRST + 500) @(posedge clock);
    bus(1'b1, 32'h0, 32'h0);
    rd_check("busy_auto_cleared", 32'h0, 32'h1);
    repeat (24 * TBIT + TRST + 200) @(posedge clock);
    #1;
    rd_check("idle_after_auto", 32'h0, 32'h0);
    check("pulses_auto", rises.size(), 48);
    if (rises.size() >= 25) check("auto_restart_spacing", rises[24] - rises[0], 24 * TBIT + TRST + 1);

    // Abort mid-bit with a simultaneous (discarded) COUNT write.
    bus(1'b1, 32'h100, 32'h00FF_FFFF);
    bus(1'b1, 32'h0, 32'h1);
    start_c = last_commit;
    rd_check("pre_abort_read", 32'h114, 32'h00A5_5A3C);
    while (cyc < start_c + 200) @(posedge clock);
    #1;
    check("high_before_abort", {31'd0, neopixel_drive}, 32'h1);
    reset_ctrl = 1'b1; write_readf = 1'b1; address = 32'h4; write_data = 32'd5; clock_ctrl = 1'b1;
    @(posedge clock); #1;
    reset_ctrl = 1'b0; clock_ctrl = 1'b0;
    check("abort_drive", {31'd0, neopixel_drive}, 32'h0);
    check("abort_rdata", read_data, 32'h0);
    rd_check("abort_busy", 32'h0, 32'h0);
    rd_check("abort_count", 32'h4, 32'd64);
    rd_check("pixel_kept", 32'h114, 32'h00A5_5A3C);
    repeat (50) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
